// File: rtl/jtag_axi_dr.sv
// rtl/jtag_axi_dr.sv - JTAG access data register with shadow output and one-cycle update pulse (TCK domain)
// Optional scan-length check: define JTAG_AXI_DR_LEN_CHECK_EN.
module jtag_axi_dr #(
    parameter  int DR_WIDTH  = 96,
    localparam int CNT_WIDTH = $clog2(DR_WIDTH + 2)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                sel_i,
    input  logic                capture_dr_i,
    input  logic                shift_dr_i,
    input  logic                update_dr_i,
    input  logic                tdi_i,
    output logic                tdo_o,
    input  logic [DR_WIDTH-1:0] axireg_i,
    output logic [DR_WIDTH-1:0] axireg_o,
    output logic                update_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_SAT = CNT_WIDTH'(DR_WIDTH + 1);

    logic [DR_WIDTH-1:0]  shift_q, shift_d;
    logic [DR_WIDTH-1:0]  shadow_q, shadow_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 upd_q, upd_d;
    logic                 prev_q, prev_d;
    logic                 do_capture, do_shift, upd_edge, accept;

    // Capture outranks shift, shift outranks update.
    assign do_capture = sel_i & capture_dr_i;
    assign do_shift   = sel_i & shift_dr_i & ~capture_dr_i;
    assign upd_edge   = sel_i & update_dr_i & ~capture_dr_i & ~shift_dr_i & ~prev_q;

`ifdef JTAG_AXI_DR_LEN_CHECK_EN
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DR_WIDTH);

    logic err_q, err_d;

    assign accept = upd_edge & (cnt_q == CNT_FULL);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    assign accept = upd_edge;
`endif

    always_comb begin
        shift_d  = shift_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        upd_d    = 1'b0;
        prev_d   = sel_i & update_dr_i;
`ifdef JTAG_AXI_DR_LEN_CHECK_EN
        err_d    = err_q;
`endif
        if (do_capture) begin
            shift_d = axireg_i;
`ifdef JTAG_AXI_DR_LEN_CHECK_EN
            // Read-back MSB is always 0 downstream, so it carries the sticky length error.
            shift_d[DR_WIDTH-1] = err_q;
            err_d               = 1'b0;
`endif
            cnt_d = '0;
        end else if (do_shift) begin
            shift_d = {tdi_i, shift_q[DR_WIDTH-1:1]};
            if (cnt_q != CNT_SAT) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (accept) begin
            shadow_d = shift_q;
            upd_d    = 1'b1;
        end
`ifdef JTAG_AXI_DR_LEN_CHECK_EN
        else if (upd_edge) begin
            err_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_q  <= '0;
            shadow_q <= '0;
            cnt_q    <= '0;
            upd_q    <= 1'b0;
            prev_q   <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            upd_q    <= upd_d;
            prev_q   <= prev_d;
        end
    end

    assign axireg_o = shadow_q;
    assign update_o = upd_q;
    assign tdo_o    = sel_i ? shift_q[0] : 1'b0;

endmodule

// File: tb/tb_jtag_axi_dr.sv
// tb/tb_jtag_axi_dr.sv - scoreboard bench for jtag_axi_dr (update pulses checked against an expected-word queue)
module tb_jtag_axi_dr;
    localparam int W = 96;
`ifdef JTAG_AXI_DR_LEN_CHECK_EN
    localparam bit LEN_CHK = 1'b1;
`else
    localparam bit LEN_CHK = 1'b0;
`endif

    logic         clk, rst, sel, cap, shf, upd, tdi, tdo, upd_o;
    logic [W-1:0] axi_in, axi_out;
    logic [W-1:0] exp_q[$];
    int           n_tests = 0;
    int           n_fail  = 0;

    localparam logic [W-1:0] W1 = 96'hDEADBEEF_CAFEF00D_1C000013;
    localparam logic [W-1:0] R  = 96'h0000_0000_1234_5678_9ABC_DEF0;

    jtag_axi_dr dut (
        .clk_i(clk), .rst_i(rst), .sel_i(sel), .capture_dr_i(cap),
        .shift_dr_i(shf), .update_dr_i(upd), .tdi_i(tdi), .tdo_o(tdo),
        .axireg_i(axi_in), .axireg_o(axi_out), .update_o(upd_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        logic [W-1:0] e;
        @(posedge clk);
        #1;
        if (upd_o !== 1'b0) begin
            n_tests++;
            if (upd_o !== 1'b1) begin
                n_fail++;
                $display("FAIL update_o_known: got %b required 0 or 1", upd_o);
            end else if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: update_o=1 required 0 (axireg_o=%h)", axi_out);
            end else begin
                e = exp_q.pop_front();
                if (axi_out !== e) begin
                    n_fail++;
                    $display("FAIL pulse_word: axireg_o=%h required %h", axi_out, e);
                end
            end
        end
    endtask

    task automatic check_drained(input string name);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_missing_pulse: %0d pulses outstanding required 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic scan(input logic [W-1:0] din, input int nshift, output logic [W-1:0] dout);
        dout = '0;
        cap = 1'b1; tick(); cap = 1'b0;
        for (int i = 0; i < nshift; i++) begin
            if (i < W) dout[i] = tdo;
            shf = 1'b1; tdi = din[i % W];
            tick();
        end
        shf = 1'b0; tdi = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        n_tests++;
        if (axi_out !== '0 || upd_o !== 1'b0 || tdo !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: axireg_o=%h update_o=%b tdo_o=%b required 0 0 0", axi_out, upd_o, tdo);
        end
        axi_in = '1;
        cap = 1'b1; tick(); cap = 1'b0;
        shf = 1'b1; tdi = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        shf = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        n_tests++;
        if (axi_out !== '0 || upd_o !== 1'b0 || tdo !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_shift: axireg_o=%h update_o=%b tdo_o=%b required 0 0 0", axi_out, upd_o, tdo);
        end
        if (!LEN_CHK) exp_q.push_back('0);
        upd = 1'b1; tick(); upd = 1'b0; tick();
        check_drained("reset_update");
    endtask

    task automatic test_store();
        logic [W-1:0] d;
        axi_in = '0;
        scan(W1, W, d);
        exp_q.push_back(W1);
        upd = 1'b1; tick(); upd = 1'b0;
        n_tests++;
        if (upd_o !== 1'b1 || axi_out !== W1) begin
            n_fail++;
            $display("FAIL store_latency: update_o=%b axireg_o=%h required 1 %h", upd_o, axi_out, W1);
        end
        tick();
        n_tests++;
        if (upd_o !== 1'b0) begin
            n_fail++;
            $display("FAIL store_pulse_width: update_o=%b required 0", upd_o);
        end
        for (int i = 0; i < 3; i++) tick();
        n_tests++;
        if (axi_out !== W1) begin
            n_fail++;
            $display("FAIL store_hold: axireg_o=%h required %h", axi_out, W1);
        end
        check_drained("store");
    endtask

    task automatic test_readback();
        logic [W-1:0] d;
        axi_in = R;
        scan({$urandom, $urandom, $urandom}, W, d);
        n_tests++;
        if (d !== R) begin
            n_fail++;
            $display("FAIL readback_seq: tdo=%h required %h", d, R);
        end
        n_tests++;
        if (axi_out !== W1) begin
            n_fail++;
            $display("FAIL readback_shadow: axireg_o=%h required %h", axi_out, W1);
        end
        check_drained("readback");
    endtask

    task automatic test_length();
        logic [W-1:0] d, m, din;
        din = 96'hA5A5_5A5A_0123_4567_89AB_CDEF;
        axi_in = R;
        m = R;
        for (int i = 0; i < W - 1; i++) m = {din[i], m[W-1:1]};
        scan(din, W - 1, d);
        if (!LEN_CHK) exp_q.push_back(m);
        upd = 1'b1; tick(); upd = 1'b0; tick();
        n_tests++;
        if (axi_out !== (LEN_CHK ? W1 : m)) begin
            n_fail++;
            $display("FAIL length_shadow: axireg_o=%h required %h", axi_out, LEN_CHK ? W1 : m);
        end
        check_drained("length");
        scan(~din, W, d);
        n_tests++;
        if (d[W-1] !== LEN_CHK || d[W-2:0] !== R[W-2:0]) begin
            n_fail++;
            $display("FAIL length_err_bit: tdo word=%h required msb %b low %h", d, LEN_CHK, R[W-2:0]);
        end
        scan(din, W, d);
        n_tests++;
        if (d !== R) begin
            n_fail++;
            $display("FAIL length_err_clear: tdo word=%h required %h", d, R);
        end
    endtask

    task automatic test_select();
        logic [W-1:0] s, h;
        logic [6:0]   c;
        axi_in = '1;
        cap = 1'b1; tick(); cap = 1'b0;
        shf = 1'b1; tdi = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        shf = 1'b0;
        s = dut.shift_q; h = dut.shadow_q; c = dut.cnt_q;
        sel = 1'b0; axi_in = '0; tdi = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cap = (k == 0); shf = (k == 1); upd = (k == 2);
            tick();
            n_tests++;
            if (tdo !== 1'b0) begin
                n_fail++;
                $display("FAIL select_tdo_%0d: tdo_o=%b required 0", k, tdo);
            end
        end
        cap = 1'b0; shf = 1'b0; upd = 1'b0; tdi = 1'b0;
        tick();
        n_tests++;
        if (dut.shift_q !== s || dut.shadow_q !== h || dut.cnt_q !== c) begin
            n_fail++;
            $display("FAIL select_hold: shift=%h shadow=%h cnt=%0d required %h %h %0d",
                     dut.shift_q, dut.shadow_q, dut.cnt_q, s, h, c);
        end
        check_drained("select");
        sel = 1'b1;
    endtask

    task automatic test_held_priority();
        logic [W-1:0] d, w2, b;
        w2 = 96'h1111_2222_3333_4444_5555_6667;
        b  = 96'h0000_0000_0F0F_0F0F_3C3C_3C3D;
        axi_in = R;
        scan(w2, W, d);
        exp_q.push_back(w2);
        upd = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        upd = 1'b0; tick(); tick();
        check_drained("held_update");
        axi_in = b;
        shf = 1'b1; tick();
        cap = 1'b1; tdi = 1'b0; tick();
        cap = 1'b0; shf = 1'b0;
        n_tests++;
        if (dut.cnt_q !== 7'd0 || dut.shift_q !== b || tdo !== 1'b1) begin
            n_fail++;
            $display("FAIL priority_capture: cnt=%0d shift=%h tdo=%b required 0 %h 1", dut.cnt_q, dut.shift_q, tdo, b);
        end
        cap = 1'b1; upd = 1'b1; tick();
        cap = 1'b0; upd = 1'b0; tick(); tick();
        check_drained("priority_cap_upd");
        scan(w2, W + 4, d);
        n_tests++;
        if (dut.cnt_q !== 7'(W + 1)) begin
            n_fail++;
            $display("FAIL cnt_saturate: cnt=%0d required %0d", dut.cnt_q, W + 1);
        end
        cap = 1'b1; tick(); cap = 1'b0; tick();
    endtask

    initial begin
        rst = 1'b1; sel = 1'b1; cap = 1'b0; shf = 1'b0; upd = 1'b0; tdi = 1'b0; axi_in = '0;
        test_reset();
        test_store();
        test_readback();
        test_length();
        test_select();
        test_held_priority();
        check_drained("final");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/jtag_axi_dr.md
Name: jtag_axi_dr

Overview:
- 96-bit JTAG data register, directly upstream of the JTAG-to-AXI master FSM.
- Serially shifts in an access word {wdata[63:0], addr[31:3], rsvd, loadstore, request} from TDI and presents it in parallel through a stable shadow register.
- Issues a one-cycle update pulse that starts the downstream AXI transaction.
- On capture, loads the downstream read-back word for shift-out on TDO.
- Runs entirely in the TCK domain; TAP state decode comes from the TAP controller.

Parameters:
- DR_WIDTH, 96, data register length in bits; must be ≥ 2.
- CNT_WIDTH, $clog2(DR_WIDTH+2), width of shift-bit counter; derived, do not override.

Ports:
- clk_i  in  1  TCK
- rst_i  in  1  async active-high reset (TRST/POR combined)
- sel_i  in  1  IR currently selects this DR
- capture_dr_i  in  1  TAP in Capture-DR
- shift_dr_i  in  1  TAP in Shift-DR
- update_dr_i  in  1  TAP in Update-DR
- tdi_i  in  1  serial data in
- tdo_o  out  1  serial data out; TAP top retimes on falling TCK
- axireg_i  in  DR_WIDTH  parallel read-back word from the downstream FSM
- axireg_o  out  DR_WIDTH  shadow register to the downstream FSM
- update_o  out  1  one-cycle pulse: axireg_o newly loaded

Behaviour:
- State: shift_q[DR_WIDTH], shadow_q[DR_WIDTH], cnt_q[CNT_WIDTH], upd_q, err_q. All are cleared to 0 asynchronously while rst_i = 1.
- Reset mid-operation: abort; no update_o pulse is generated for a partially shifted word.
- Reset values: axireg_o = 0, update_o = 0, tdo_o = 0.
- Combinational outputs:
  - axireg_o = shadow_q.
  - update_o = upd_q.
  - tdo_o = sel_i ? shift_q[0] : 0.
- With sel_i = 0:
  - Every strobe is ignored.
  - upd_q still clears to 0 the next cycle.
  - All other state holds.
- Strobe priority when more than one is high (TAP guarantees one-hot; priority is defined for robustness): capture > shift > update.
- Capture (sel_i & capture_dr_i):
  - shift_q <= axireg_i.
  - cnt_q <= 0.
  - See Optional Feature for bit DR_WIDTH-1.
- Shift (sel_i & shift_dr_i):
  - shift_q <= {tdi_i, shift_q[DR_WIDTH-1:1]}, LSB first out, MSB first in.
  - cnt_q increments and saturates at DR_WIDTH+1; it never wraps.
- Update (sel_i & update_dr_i), when the update is accepted:
  - shadow_q <= shift_q.
  - upd_q <= 1.
  - Latency: update_o and the new axireg_o appear in the cycle after update_dr_i is sampled, both on the same edge.
  - axireg_o stays stable until the next accepted update.
- upd_q is always a single-cycle pulse: it clears the cycle after it is set, even if update_dr_i stays high. Update-DR held for N cycles produces one pulse only. This uses an edge detect on (sel_i & update_dr_i), tracked by an internal prev flag that is cleared on reset.
- Back-to-back DR scans are allowed. The downstream FSM absorbs an extra pulse as a new request, so no busy back-pressure is applied here.

Optional Feature:
- Macro: JTAG_AXI_DR_LEN_CHECK_EN.
- Defined:
  - An update is accepted only if cnt_q == DR_WIDTH, i.e. exactly DR_WIDTH shift cycles since the last capture.
  - Otherwise: shadow_q holds, no update_o pulse, err_q <= 1 (sticky).
  - On capture, shift_q[DR_WIDTH-1] <= err_q instead of axireg_i[DR_WIDTH-1], and err_q clears on the same edge. The error is therefore reported in the MSB of the next scan-out, then cleared.
  - This is safe because the downstream read-back word drives bits 95:64 to 0.
- Undefined:
  - Every selected update is accepted regardless of cnt_q.
  - err_q is tied to 0 and optimised away.
  - Capture loads axireg_i unmodified.

Test Plan:
- Reset/idle: assert rst_i mid-shift for 1 cycle -> axireg_o = 0, update_o = 0, tdo_o = 0; the following update_dr_i with no shifts gives no pulse (check enabled).
- Store scan: capture, shift 96 bits of {64'hDEADBEEF_CAFEF00D, 32'h1C00_0013}, update -> exactly one update_o pulse one cycle after update_dr_i; axireg_o = 96'hDEADBEEF_CAFEF00D_1C000013 and held stable afterwards.
- Read-back: axireg_i = 96'h0000_0000_1234_5678_9ABC_DEF0, capture, then 96 shifts -> tdo_o serial sequence equals axireg_i, LSB first; shadow unchanged throughout with no update.
- Length error (macro on): capture, 95 shifts, update -> no pulse, axireg_o unchanged. Next capture + 96 shifts -> bit 95 shifted out = 1. A further capture shifts out bit 95 = 0. With the macro off, the same stimulus yields a pulse.
- Select gating: sel_i = 0 while pulsing capture/shift/update -> shift_q, shadow_q and cnt_q unchanged; tdo_o = 0; no update_o.
- Held update/priority: update_dr_i high for 3 cycles -> one pulse. capture_dr_i and shift_dr_i high together -> capture wins and cnt_q = 0.
